ram_tdp_param: RTL and testbench
================================

RAM_TDP_PARAM -- requirements
Module: ram_tdp_param

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 6: address width; depth = 2**ADDR_W words.
REQ-003 Parameter RD_MODE, default 0: same-port read-during-write; 0 = write-first (new data), 1 = read-first (old data).
REQ-004 Parameter OUT_REG, default 0: 1 adds one output pipeline stage on both ports.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en_a / en_b  input  1  port access enable; no read or write when low.
REQ-008 we_a / we_b  input  1  write enable; qualified by en_x.
REQ-009 addr_a / addr_b  input  ADDR_W  word address.
REQ-010 data_a / data_b  input  DATA_W  write data.
REQ-011 be_a / be_b  input  DATA_W/8  byte enables; bit i covers data bits [8i+7:8i].
REQ-012 q_a / q_b  output  DATA_W  registered read data.
REQ-013 vld_a / vld_b  output  1  q_x holds the result of an access issued 1+OUT_REG cycles earlier.
REQ-014 coll  output  1  one-cycle pulse: write/write collision on same address.
REQ-015 coll_cnt  output  16  collision count (see Configuration).

Function
REQ-016 Access on port x occurs at a rising edge where en_x=1; write when we_x=1, else read.
REQ-017 A write SHALL update only bytes whose be_x bit is 1; other bytes keep their stored value.
REQ-018 Read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), identical for both ports.
REQ-019 vld_x SHALL be en_x delayed by the read latency, for both reads and writes.
REQ-020 When en_x=0, q_x SHALL hold its previous value and vld_x SHALL be 0 after the latency.
REQ-021 Same-port write, RD_MODE=0: q_x SHALL return the merged word (new enabled bytes, old other bytes).
REQ-022 Same-port write, RD_MODE=1: q_x SHALL return the word stored before the write.
REQ-023 Cross-port read of an address written by the other port in the same cycle SHALL return the old word.
REQ-024 Both ports write the same address in one cycle: each byte enabled on A takes A data; bytes enabled only on B take B data.
REQ-025 coll SHALL pulse high the cycle after REQ-024 occurs, regardless of be overlap; never for a read/write or read/read pair.
REQ-026 Different addresses SHALL be fully independent on both ports in every cycle.
REQ-027 Addresses wrap naturally within 2**ADDR_W; no out-of-range condition exists.

Reset
REQ-028 While rst=1: q_a, q_b = 0; vld_a, vld_b, coll = 0; coll_cnt = 0; pipeline stages cleared.
REQ-029 Memory contents SHALL NOT be reset; a write in flight when rst asserts MAY be lost, no other word altered.
REQ-030 First access SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-031 Macro RAM_TDP_COLL_CNT_EN defined: coll_cnt increments by 1 on each coll pulse, saturating at 16'hFFFF.
REQ-032 Macro undefined: coll_cnt SHALL be constant 0 with no counter logic; coll still functional.

Verification
REQ-033 Defaults; A writes 0x5A to addr 3, next cycle B reads addr 3 -> q_b=0x5A, vld_b=1 one cycle later.
REQ-034 DATA_W=16; word 0x1234 at addr 7; A writes 0xABCD with be_a=2'b01 -> addr 7 reads 0x12CD.
REQ-035 Same cycle A writes 0x11, B writes 0x22 to addr 9 -> addr 9 reads 0x11; coll pulses one cycle; coll_cnt=1 with macro, 0 without.
REQ-036 addr 4 holds 0x00; A writes 0xFF while B reads addr 4 -> q_b=0x00; q_a=0xFF (RD_MODE=0) or 0x00 (RD_MODE=1).
REQ-037 OUT_REG=1; B reads addr 2 (holds 0x3C) -> q_b=0x3C and vld_b=1 exactly 2 cycles after issue.
REQ-038 Assert rst mid-stream with reads pending -> q_x, vld_x, coll, coll_cnt all 0 immediately; earlier writes still readable after release.

Source files
------------

// File: rtl/ram_tdp_param_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_tdp_param_if : port bundle for the true dual-port RAM         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface ram_tdp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic                en_a;
  logic                en_b;
  logic                we_a;
  logic                we_b;
  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W-1:0]   addr_b;
  logic [DATA_W-1:0]   data_a;
  logic [DATA_W-1:0]   data_b;
  logic [DATA_W/8-1:0] be_a;
  logic [DATA_W/8-1:0] be_b;
  logic [DATA_W-1:0]   q_a;
  logic [DATA_W-1:0]   q_b;
  logic                vld_a;
  logic                vld_b;
  logic                coll;
  logic [15:0]         coll_cnt;

  modport master (
    output en_a, en_b, we_a, we_b, addr_a, addr_b, data_a, data_b, be_a, be_b,
    input  q_a, q_b, vld_a, vld_b, coll, coll_cnt
  );

  modport slave (
    input  en_a, en_b, we_a, we_b, addr_a, addr_b, data_a, data_b, be_a, be_b,
    output q_a, q_b, vld_a, vld_b, coll, coll_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ram_tdp_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_tdp_param : true dual-port byte-enable RAM, optional output   |
// | stage; RAM_TDP_COLL_CNT_EN enables coll_cnt. Rev 1.0              |
// +------------------------------------------------------------------+
module ram_tdp_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input wire logic       clk,
  input wire logic       rst,
  ram_tdp_param_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_a, wr_b, same_ww;
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

  always_comb begin
    wr_a    = bus.en_a & bus.we_a & ~rst;
    wr_b    = bus.en_b & bus.we_b & ~rst;
    same_ww = wr_a & wr_b & (bus.addr_a == bus.addr_b);
    old_a   = mem[bus.addr_a];
    old_b   = mem[bus.addr_b];
    new_a   = old_a;
    new_b   = old_b;
    // On a write/write collision port A owns its enabled bytes, B fills the rest
    for (int i = 0; i < NB; i++) begin
      if (bus.be_b[i]) new_b[8*i +: 8] = bus.data_b[8*i +: 8];
      if (bus.be_a[i]) new_a[8*i +: 8] = bus.data_a[8*i +: 8];
      else if (same_ww && bus.be_b[i]) new_a[8*i +: 8] = bus.data_b[8*i +: 8];
    end
    if (same_ww) new_b = new_a;
    rd_a = (RD_MODE == 0 && wr_a) ? new_a : old_a;
    rd_b = (RD_MODE == 0 && wr_b) ? new_b : old_b;
  end

  always_ff @(posedge clk) begin
    if (wr_b) mem[bus.addr_b] <= new_b;
    if (wr_a) mem[bus.addr_a] <= new_a;
  end

  logic [DATA_W-1:0] q1_a_d, q1_a_q, q1_b_d, q1_b_q;
  logic              vld1_a_d, vld1_a_q, vld1_b_d, vld1_b_q;
  logic              coll_d, coll_q;

  always_comb begin
    q1_a_d   = bus.en_a ? rd_a : q1_a_q;
    q1_b_d   = bus.en_b ? rd_b : q1_b_q;
    vld1_a_d = bus.en_a;
    vld1_b_d = bus.en_b;
    coll_d   = same_ww;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_a_q   <= '0;
      q1_b_q   <= '0;
      vld1_a_q <= 1'b0;
      vld1_b_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      q1_a_q   <= q1_a_d;
      q1_b_q   <= q1_b_d;
      vld1_a_q <= vld1_a_d;
      vld1_b_q <= vld1_b_d;
      coll_q   <= coll_d;
    end
  end

  assign bus.coll = coll_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] q2_a_d, q2_a_q, q2_b_d, q2_b_q;
      logic              vld2_a_d, vld2_a_q, vld2_b_d, vld2_b_q;

      always_comb begin
        q2_a_d   = vld1_a_q ? q1_a_q : q2_a_q;
        q2_b_d   = vld1_b_q ? q1_b_q : q2_b_q;
        vld2_a_d = vld1_a_q;
        vld2_b_d = vld1_b_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q2_a_q   <= '0;
          q2_b_q   <= '0;
          vld2_a_q <= 1'b0;
          vld2_b_q <= 1'b0;
        end else begin
          q2_a_q   <= q2_a_d;
          q2_b_q   <= q2_b_d;
          vld2_a_q <= vld2_a_d;
          vld2_b_q <= vld2_b_d;
        end
      end

      assign bus.q_a   = q2_a_q;
      assign bus.q_b   = q2_b_q;
      assign bus.vld_a = vld2_a_q;
      assign bus.vld_b = vld2_b_q;
    end else begin : g_no_out_reg
      assign bus.q_a   = q1_a_q;
      assign bus.q_b   = q1_b_q;
      assign bus.vld_a = vld1_a_q;
      assign bus.vld_b = vld1_b_q;
    end
  endgenerate

`ifdef RAM_TDP_COLL_CNT_EN
  logic [15:0] coll_cnt_d, coll_cnt_q;

  // Counts alongside the coll flop so both change on the same edge
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (same_ww && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_cnt_q <= 16'd0;
    else     coll_cnt_q <= coll_cnt_d;
  end

  assign bus.coll_cnt = coll_cnt_q;
`else
  assign bus.coll_cnt = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ram_tdp_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ram_tdp_param : directed bench, 16-bit write-first/no out reg  |
// | and 8-bit read-first/out reg instances. Rev 1.0                   |
// +------------------------------------------------------------------+
module tb_ram_tdp_param;
`ifdef RAM_TDP_COLL_CNT_EN
  localparam int COLL_INC = 1;
`else
  localparam int COLL_INC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ram_tdp_param_if #(.DATA_W(16), .ADDR_W(6)) ifc0 ();
  ram_tdp_param_if #(.DATA_W(8),  .ADDR_W(6)) ifc1 ();

  ram_tdp_param #(.DATA_W(16), .ADDR_W(6), .RD_MODE(0), .OUT_REG(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0)
  );

  ram_tdp_param #(.DATA_W(8), .ADDR_W(6), .RD_MODE(1), .OUT_REG(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a0(input logic en, input logic we, input logic [5:0] addr,
                        input logic [15:0] data, input logic [1:0] be);
    ifc0.en_a = en; ifc0.we_a = we; ifc0.addr_a = addr; ifc0.data_a = data; ifc0.be_a = be;
  endtask

  task automatic set_b0(input logic en, input logic we, input logic [5:0] addr,
                        input logic [15:0] data, input logic [1:0] be);
    ifc0.en_b = en; ifc0.we_b = we; ifc0.addr_b = addr; ifc0.data_b = data; ifc0.be_b = be;
  endtask

  task automatic set_a1(input logic en, input logic we, input logic [5:0] addr,
                        input logic [7:0] data, input logic be);
    ifc1.en_a = en; ifc1.we_a = we; ifc1.addr_a = addr; ifc1.data_a = data; ifc1.be_a = be;
  endtask

  task automatic set_b1(input logic en, input logic we, input logic [5:0] addr,
                        input logic [7:0] data, input logic be);
    ifc1.en_b = en; ifc1.we_b = we; ifc1.addr_b = addr; ifc1.data_b = data; ifc1.be_b = be;
  endtask

  task automatic idle();
    set_a0(1'b0, 1'b0, 6'd0, 16'h0, 2'b00);
    set_b0(1'b0, 1'b0, 6'd0, 16'h0, 2'b00);
    set_a1(1'b0, 1'b0, 6'd0, 8'h0, 1'b0);
    set_b1(1'b0, 1'b0, 6'd0, 8'h0, 1'b0);
  endtask

  initial begin
    idle();
    cyc(); cyc();
    check("rst_q_a0",  ifc0.q_a, 16'h0);
    check("rst_q_b0",  ifc0.q_b, 16'h0);
    check("rst_vld_a0", {15'd0, ifc0.vld_a}, 16'h0);
    check("rst_coll0", {15'd0, ifc0.coll}, 16'h0);
    check("rst_cnt0",  ifc0.coll_cnt, 16'h0);
    check("rst_vld_b1", {15'd0, ifc1.vld_b}, 16'h0);
    rst = 1'b0;

    // Write then cross-port read
    set_a0(1, 1, 6'd3, 16'h005A, 2'b11); cyc();
    check("wf_q_a0",   ifc0.q_a, 16'h005A);
    check("wf_vld_a0", {15'd0, ifc0.vld_a}, 16'h1);
    idle(); set_b0(1, 0, 6'd3, 16'h0, 2'b00); cyc();
    check("rd3_q_b0",   ifc0.q_b, 16'h005A);
    check("rd3_vld_b0", {15'd0, ifc0.vld_b}, 16'h1);
    check("idle_vld_a0", {15'd0, ifc0.vld_a}, 16'h0);
    check("hold_q_a0", ifc0.q_a, 16'h005A);

    // Byte-enable merge
    idle(); set_a0(1, 1, 6'd7, 16'h1234, 2'b11); cyc();
    set_a0(1, 1, 6'd7, 16'hABCD, 2'b01); cyc();
    check("be_q_a0", ifc0.q_a, 16'h12CD);
    idle(); set_b0(1, 0, 6'd7, 16'h0, 2'b00); cyc();
    check("be_q_b0", ifc0.q_b, 16'h12CD);

    // Write/write collision, full and partial byte enables
    idle(); set_a0(1, 1, 6'd9, 16'h0011, 2'b11); set_b0(1, 1, 6'd9, 16'h0022, 2'b11); cyc();
    check("coll1", {15'd0, ifc0.coll}, 16'h1);
    idle(); cyc();
    check("coll1_end", {15'd0, ifc0.coll}, 16'h0);
    check("cnt1", ifc0.coll_cnt, 16'(COLL_INC));
    set_b0(1, 0, 6'd9, 16'h0, 2'b00); cyc();
    check("coll1_data", ifc0.q_b, 16'h0011);
    idle(); set_a0(1, 1, 6'd10, 16'h00AA, 2'b01); set_b0(1, 1, 6'd10, 16'hBBCC, 2'b11); cyc();
    check("coll2", {15'd0, ifc0.coll}, 16'h1);
    idle(); set_a0(1, 0, 6'd10, 16'h0, 2'b00); cyc();
    check("coll2_data", ifc0.q_a, 16'hBBAA);
    check("coll2_end", {15'd0, ifc0.coll}, 16'h0);
    check("cnt2", ifc0.coll_cnt, 16'(2 * COLL_INC));

    // Write on A, read on B, same address: B sees old word, no collision
    idle(); set_a0(1, 1, 6'd4, 16'h0000, 2'b11); cyc();
    set_a0(1, 1, 6'd4, 16'h00FF, 2'b11); set_b0(1, 0, 6'd4, 16'h0, 2'b00); cyc();
    check("rw_q_b0", ifc0.q_b, 16'h0000);
    check("rw_q_a0", ifc0.q_a, 16'h00FF);
    check("rw_coll0", {15'd0, ifc0.coll}, 16'h0);
    idle(); cyc();
    check("en0_vld_a0", {15'd0, ifc0.vld_a}, 16'h0);
    check("en0_q_a0", ifc0.q_a, 16'h00FF);

    // Reset mid-stream on the unregistered instance
    set_b0(1, 0, 6'd7, 16'h0, 2'b00); cyc();
    check("pre_rst_q_b0", ifc0.q_b, 16'h12CD);
    set_b0(1, 0, 6'd4, 16'h0, 2'b00);
    rst = 1'b1; #1;
    check("mrst_q_b0", ifc0.q_b, 16'h0);
    check("mrst_vld_b0", {15'd0, ifc0.vld_b}, 16'h0);
    check("mrst_cnt0", ifc0.coll_cnt, 16'h0);
    idle(); cyc(); rst = 1'b0;
    set_b0(1, 0, 6'd10, 16'h0, 2'b00); cyc();
    check("post_rst_q_b0", ifc0.q_b, 16'hBBAA);
    check("post_rst_vld_b0", {15'd0, ifc0.vld_b}, 16'h1);

    // Output-registered instance: two-cycle latency
    idle(); set_a1(1, 1, 6'd2, 8'h3C, 1'b1); cyc();
    check("lat_vld_a1_c1", {15'd0, ifc1.vld_a}, 16'h0);
    idle(); cyc();
    check("lat_vld_a1_c2", {15'd0, ifc1.vld_a}, 16'h1);
    cyc();
    check("lat_vld_a1_c3", {15'd0, ifc1.vld_a}, 16'h0);
    set_b1(1, 0, 6'd2, 8'h0, 1'b0); cyc();
    check("lat_vld_b1_c1", {15'd0, ifc1.vld_b}, 16'h0);
    idle(); cyc();
    check("lat_q_b1", {8'd0, ifc1.q_b}, 16'h003C);
    check("lat_vld_b1_c2", {15'd0, ifc1.vld_b}, 16'h1);

    // Read-first on the writing port
    set_a1(1, 1, 6'd4, 8'h00, 1'b1); cyc(); idle(); cyc();
    set_a1(1, 1, 6'd4, 8'hFF, 1'b1); set_b1(1, 0, 6'd4, 8'h0, 1'b0); cyc();
    idle(); cyc();
    check("rf_q_a1", {8'd0, ifc1.q_a}, 16'h0000);
    check("rf_q_b1", {8'd0, ifc1.q_b}, 16'h0000);
    set_b1(1, 0, 6'd4, 8'h0, 1'b0); cyc(); idle(); cyc();
    check("rf_new_q_b1", {8'd0, ifc1.q_b}, 16'h00FF);
    cyc();
    check("rf_hold_vld_b1", {15'd0, ifc1.vld_b}, 16'h0);
    check("rf_hold_q_b1", {8'd0, ifc1.q_b}, 16'h00FF);

    // Reset with a read in the pipeline
    set_b1(1, 0, 6'd2, 8'h0, 1'b0); cyc(); idle();
    rst = 1'b1; #1;
    check("mrst_q_b1", {8'd0, ifc1.q_b}, 16'h0);
    check("mrst_vld_b1", {15'd0, ifc1.vld_b}, 16'h0);
    cyc();
    check("mrst_vld_b1_c1", {15'd0, ifc1.vld_b}, 16'h0);
    rst = 1'b0; cyc();
    check("post_rst_vld_b1", {15'd0, ifc1.vld_b}, 16'h0);
    set_b1(1, 0, 6'd4, 8'h0, 1'b0); cyc(); idle(); cyc();
    check("post_rst_q_b1", {8'd0, ifc1.q_b}, 16'h00FF);
    check("post_rst_vld_b1_2", {15'd0, ifc1.vld_b}, 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
